// File: rtl/mem_bus_responder_if.sv
// rtl/mem_bus_responder_if.sv - request/done handshake and status signals of the memory responder
interface mem_bus_responder_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic              read_q;
    logic              write_q;
    logic              read_dn;
    logic              write_dn;
    logic              bus_busy;
    logic              addr_err;
    logic              proto_err;

    modport master (
        output addr, read_q, write_q,
        input  read_dn, write_dn, bus_busy, addr_err, proto_err
    );

    modport slave (
        input  addr, read_q, write_q,
        output read_dn, write_dn, bus_busy, addr_err, proto_err
    );
endinterface

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - word-addressed RAM responder with wait states and 4-phase done handshake
module mem_bus_responder #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 256,
    parameter int RD_WAIT   = 2,
    parameter int WR_WAIT   = 1
) (
    input  logic               clk,
    input  logic               rst,
    mem_bus_responder_if.slave bus,
    inout  wire  [DATA_W-1:0]  data
);
    localparam int                IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0]        RD_CNT = 4'(RD_WAIT);
    localparam logic [3:0]        WR_CNT = 4'(WR_WAIT);
    localparam logic [ADDR_W-1:0] DEPTH  = ADDR_W'(MEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_DONE,
        S_WR_WAIT,
        S_WR_DONE
    } state_t;

    state_t              state, state_next;
    logic [3:0]          cnt, cnt_next;
    logic                issued, issued_next;
    logic                proto_next;
    logic                accept_rd, accept_wr;
    logic                mem_rd_en, mem_we, load_rd, set_err;
    logic                proto_err, addr_err;
    logic [ADDR_W-1:0]   addr_lat;
    logic [DATA_W-1:0]   wr_lat;
    logic [DATA_W-1:0]   rd_data;
    logic [DATA_W-1:0]   ram_q;
    logic                oor;
    logic [IDX_W-1:0]    idx;

    logic [DATA_W-1:0]   mem [MEM_DEPTH];

    assign oor = (addr_lat >= DEPTH);
    assign idx = addr_lat[IDX_W-1:0];

    // The wait phase spends one extra cycle after the counter expires: the RAM
    // access (read fetch or write commit) happens there, so done rises WAIT+2
    // cycles after acceptance.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        issued_next = issued;
        proto_next  = 1'b0;
        accept_rd   = 1'b0;
        accept_wr   = 1'b0;
        mem_rd_en   = 1'b0;
        mem_we      = 1'b0;
        load_rd     = 1'b0;
        set_err     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.read_q && bus.write_q) begin
                    proto_next = 1'b1;
                end else if (bus.read_q) begin
                    accept_rd   = 1'b1;
                    cnt_next    = RD_CNT;
                    issued_next = 1'b0;
                    state_next  = S_RD_WAIT;
                end else if (bus.write_q) begin
                    accept_wr   = 1'b1;
                    cnt_next    = WR_CNT;
                    issued_next = 1'b0;
                    state_next  = S_WR_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (bus.write_q) proto_next = 1'b1;
                if (issued) begin
                    load_rd     = 1'b1;
                    issued_next = 1'b0;
                    state_next  = S_RD_DONE;
                    if (!bus.read_q) proto_next = 1'b1;
                end else if (cnt == 4'd0) begin
                    mem_rd_en   = !oor;
                    set_err     = oor;
                    issued_next = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            S_RD_DONE: begin
                if (bus.write_q) proto_next = 1'b1;
                if (!bus.read_q) state_next = S_IDLE;
            end
            S_WR_WAIT: begin
                if (bus.read_q) proto_next = 1'b1;
                if (issued) begin
                    issued_next = 1'b0;
                    state_next  = S_WR_DONE;
                    if (!bus.write_q) proto_next = 1'b1;
                end else if (cnt == 4'd0) begin
                    mem_we      = !oor;
                    set_err     = oor;
                    issued_next = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            S_WR_DONE: begin
                if (bus.read_q) proto_next = 1'b1;
                if (!bus.write_q) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            issued    <= 1'b0;
            proto_err <= 1'b0;
            addr_err  <= 1'b0;
            addr_lat  <= '0;
            wr_lat    <= '0;
            rd_data   <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            issued    <= issued_next;
            proto_err <= proto_next;
            if (set_err) addr_err <= 1'b1;
            if (accept_rd || accept_wr) addr_lat <= bus.addr;
            if (accept_wr) wr_lat <= data;
            if (load_rd) rd_data <= oor ? '0 : ram_q;
        end
    end

    // RAM has no reset so it maps onto block memory; an asynchronous reset
    // forces IDLE, which drops mem_we before the next edge.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= wr_lat;
        if (mem_rd_en) ram_q <= mem[idx];
    end

    assign bus.read_dn   = (state == S_RD_DONE);
    assign bus.write_dn  = (state == S_WR_DONE);
    assign bus.bus_busy  = (state != S_IDLE);
    assign bus.addr_err  = addr_err;
    assign bus.proto_err = proto_err;
    assign data          = (state == S_RD_DONE) ? rd_data : {DATA_W{1'bz}};
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - randomized self-checking bench for mem_bus_responder
module tb_mem_bus_responder;
    localparam int RD_W   = 2;
    localparam int WR_W   = 1;
    localparam int DEPTH  = 256;
    localparam int RD_LAT = RD_W + 2;
    localparam int WR_LAT = WR_W + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tb_oe = 1'b1;
    logic [31:0] tb_data = 32'h0;
    wire  [31:0] data;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] mm [logic [31:0]];
    bit          model_err = 1'b0;

    mem_bus_responder_if #(.ADDR_W(32)) b ();

    mem_bus_responder #(
        .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(DEPTH), .RD_WAIT(RD_W), .WR_WAIT(WR_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(b), .data(data)
    );

    assign data = tb_oe ? tb_data : 32'hzzzz_zzzz;

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // One complete transfer; reports what was observed, no judging here.
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input int hold, input int drop_at, input int opp_at,
                        output int lat, output int dn_cyc, output logic [31:0] rd,
                        output int pcnt, output bit busy_ok, output bit bus_ok, output bit closed);
        bit seen, req, dn;
        lat = -1; dn_cyc = 0; rd = '0; pcnt = 0;
        busy_ok = 1'b1; bus_ok = 1'b1; closed = 1'b0; seen = 1'b0; req = 1'b1;
        b.addr = a; tb_oe = 1'b1; tb_data = wr ? wd : 32'h0;
        if (wr) b.write_q = 1'b1; else b.read_q = 1'b1;
        for (int n = 1; n <= 64 && !closed; n++) begin
            @(negedge clk);
            if (b.proto_err) pcnt++;
            dn = wr ? b.write_dn : b.read_dn;
            if (dn) begin
                dn_cyc++;
                if (!b.bus_busy) busy_ok = 1'b0;
                if (!seen) begin
                    seen = 1'b1; lat = n - 1;
                    if (!wr) begin tb_oe = 1'b0; #1; rd = data; end
                end else if (!wr) begin
                    #1; if (data !== rd) bus_ok = 1'b0;
                end
            end else if (seen) begin
                if (b.bus_busy) busy_ok = 1'b0;
                tb_oe = 1'b1; tb_data = 32'h0; #1;
                if (data !== 32'h0) bus_ok = 1'b0;
                closed = 1'b1;
            end else begin
                if (!b.bus_busy) busy_ok = 1'b0;
                if (data !== tb_data) bus_ok = 1'b0;
            end
            if (n == 1) begin b.addr = $urandom; if (wr) tb_data = $urandom; end
            if (n == opp_at) begin if (wr) b.read_q = 1'b1; else b.write_q = 1'b1; end
            if (n == opp_at + 1) begin if (wr) b.read_q = 1'b0; else b.write_q = 1'b0; end
            if (req && ((drop_at > 0 && n == drop_at) || (drop_at < 0 && seen && dn_cyc > hold))) begin
                req = 1'b0;
                if (wr) b.write_q = 1'b0; else b.read_q = 1'b0;
            end
        end
        b.read_q = 1'b0; b.write_q = 1'b0; tb_oe = 1'b1; tb_data = 32'h0;
    endtask

    task automatic test_reset();
        b.addr = '0; b.read_q = 1'b0; b.write_q = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({b.read_dn, b.write_dn, b.bus_busy, b.addr_err, b.proto_err} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs: got %b expected 00000",
                {b.read_dn, b.write_dn, b.bus_busy, b.addr_err, b.proto_err});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({b.read_dn, b.write_dn, b.bus_busy, b.proto_err} !== 4'b0 || data !== 32'h0) begin
            errors++; $display("FAIL post_reset_idle: got %b data %h expected 0000 data 0",
                {b.read_dn, b.write_dn, b.bus_busy, b.proto_err}, data);
        end
    endtask

    task automatic test_write_read();
        int lat, dc, pc; logic [31:0] rd; bit bo, do_, cl;
        xfer(1'b1, 32'd5, 32'hDEADBEEF, 0, -1, -5, lat, dc, rd, pc, bo, do_, cl);
        mm[32'd5] = 32'hDEADBEEF;
        checks++; if (lat !== WR_LAT || !cl) begin errors++; $display("FAIL wr_latency: got %0d expected %0d", lat, WR_LAT); end
        checks++; if (pc !== 0 || !bo || !do_) begin errors++; $display("FAIL wr_clean: got proto %0d busy_ok %0d bus_ok %0d expected 0 1 1", pc, bo, do_); end
        xfer(1'b0, 32'd5, 32'h0, 0, -1, -5, lat, dc, rd, pc, bo, do_, cl);
        checks++; if (lat !== RD_LAT || !cl) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", lat, RD_LAT); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
        checks++; if (dc !== 1 || !do_ || !bo) begin errors++; $display("FAIL rd_handshake: got dn %0d bus_ok %0d busy_ok %0d expected 1 1 1", dc, do_, bo); end
        checks++; if (b.addr_err !== 1'b0) begin errors++; $display("FAIL addr_err_clean: got %b expected 0", b.addr_err); end
    endtask

    task automatic test_held();
        int lat, dc, pc; logic [31:0] rd; bit bo, do_, cl;
        xfer(1'b0, 32'd5, 32'h0, 10, -1, -5, lat, dc, rd, pc, bo, do_, cl);
        checks++; if (dc !== 11 || !cl) begin errors++; $display("FAIL held_dn_cycles: got %0d expected 11", dc); end
        checks++; if (!do_ || !bo || rd !== mm[32'd5]) begin errors++; $display("FAIL held_stable: got bus_ok %0d busy_ok %0d data %h expected 1 1 %h", do_, bo, rd, mm[32'd5]); end
    endtask

    task automatic test_early_drop();
        int lat, dc, pc; logic [31:0] rd; bit bo, do_, cl;
        logic [31:0] wd;
        wd = $urandom;
        xfer(1'b1, 32'd9, wd, 0, 1, -5, lat, dc, rd, pc, bo, do_, cl);
        mm[32'd9] = wd;
        checks++; if (lat !== WR_LAT || dc !== 1 || !cl) begin errors++; $display("FAIL early_drop_dn: got lat %0d dn %0d expected %0d 1", lat, dc, WR_LAT); end
        checks++; if (pc !== 1) begin errors++; $display("FAIL early_drop_proto: got %0d expected 1", pc); end
        xfer(1'b0, 32'd9, 32'h0, 0, -1, -5, lat, dc, rd, pc, bo, do_, cl);
        checks++; if (rd !== wd) begin errors++; $display("FAIL early_drop_commit: got %h expected %h", rd, wd); end
    endtask

    task automatic test_opposite();
        int lat, dc, pc; logic [31:0] rd; bit bo, do_, cl;
        logic [31:0] wd;
        wd = $urandom;
        xfer(1'b0, 32'd5, 32'h0, 0, -1, 1, lat, dc, rd, pc, bo, do_, cl);
        checks++; if (pc !== 1 || rd !== mm[32'd5] || !cl) begin errors++; $display("FAIL opposite_in_read: got proto %0d data %h expected 1 %h", pc, rd, mm[32'd5]); end
        xfer(1'b1, 32'd6, wd, 0, -1, -5, lat, dc, rd, pc, bo, do_, cl);
        mm[32'd6] = wd;
        checks++; if (lat !== WR_LAT || pc !== 0 || !cl) begin errors++; $display("FAIL after_opposite_write: got lat %0d proto %0d expected %0d 0", lat, pc, WR_LAT); end
        xfer(1'b0, 32'd6, 32'h0, 0, -1, -5, lat, dc, rd, pc, bo, do_, cl);
        checks++; if (rd !== wd) begin errors++; $display("FAIL after_opposite_read: got %h expected %h", rd, wd); end
    endtask

    task automatic test_simultaneous();
        int lat, dc, pc, pulses; logic [31:0] rd; bit bo, do_, cl, bad;
        pulses = 0; bad = 1'b0;
        b.addr = 32'd5; b.read_q = 1'b1; b.write_q = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (b.proto_err) pulses++;
            if (b.read_dn || b.write_dn || b.bus_busy) bad = 1'b1;
        end
        b.write_q = 1'b0;
        checks++; if (pulses !== 3) begin errors++; $display("FAIL simul_proto: got %0d expected 3", pulses); end
        checks++; if (bad) begin errors++; $display("FAIL simul_no_accept: got accepted expected idle"); end
        xfer(1'b0, 32'd5, 32'h0, 0, -1, -5, lat, dc, rd, pc, bo, do_, cl);
        checks++; if (lat !== RD_LAT || rd !== mm[32'd5] || pc !== 0) begin errors++; $display("FAIL simul_then_read: got lat %0d data %h proto %0d expected %0d %h 0", lat, rd, pc, RD_LAT, mm[32'd5]); end
    endtask

    task automatic test_out_of_range();
        int lat, dc, pc; logic [31:0] rd; bit bo, do_, cl;
        logic [31:0] v0;
        v0 = $urandom;
        xfer(1'b1, 32'd0, v0, 0, -1, -5, lat, dc, rd, pc, bo, do_, cl);
        mm[32'd0] = v0;
        xfer(1'b0, 32'd300, 32'h0, 0, -1, -5, lat, dc, rd, pc, bo, do_, cl);
        model_err = 1'b1;
        checks++; if (rd !== 32'h0 || lat !== RD_LAT || !cl) begin errors++; $display("FAIL oor_read: got data %h lat %0d expected 0 %0d", rd, lat, RD_LAT); end
        checks++; if (b.addr_err !== 1'b1) begin errors++; $display("FAIL oor_addr_err: got %b expected 1", b.addr_err); end
        xfer(1'b1, 32'd256, ~v0, 0, -1, -5, lat, dc, rd, pc, bo, do_, cl);
        checks++; if (lat !== WR_LAT || !cl) begin errors++; $display("FAIL oor_write_done: got %0d expected %0d", lat, WR_LAT); end
        xfer(1'b1, 32'h8000_0105, 32'h1234_5678, 0, -1, -5, lat, dc, rd, pc, bo, do_, cl);
        xfer(1'b0, 32'd0, 32'h0, 0, -1, -5, lat, dc, rd, pc, bo, do_, cl);
        checks++; if (rd !== v0) begin errors++; $display("FAIL oor_no_wrap0: got %h expected %h", rd, v0); end
        xfer(1'b0, 32'd5, 32'h0, 0, -1, -5, lat, dc, rd, pc, bo, do_, cl);
        checks++; if (rd !== mm[32'd5]) begin errors++; $display("FAIL oor_no_wrap5: got %h expected %h", rd, mm[32'd5]); end
        checks++; if (b.addr_err !== 1'b1) begin errors++; $display("FAIL addr_err_sticky: got %b expected 1", b.addr_err); end
    endtask

    task automatic test_random();
        int lat, dc, pc, hold, exp_lat; logic [31:0] rd, a, wd; bit bo, do_, cl, wr, oor;
        for (int i = 0; i < 24; i++) begin
            wr   = 1'($urandom_range(0, 1));
            hold = $urandom_range(0, 3);
            wd   = $urandom;
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_0100;
            else a = 32'($urandom_range(0, 15));
            oor = (a >= 32'(DEPTH));
            xfer(wr, a, wd, hold, -1, -5, lat, dc, rd, pc, bo, do_, cl);
            exp_lat = wr ? WR_LAT : RD_LAT;
            if (oor) model_err = 1'b1;
            checks++; if (lat !== exp_lat || dc !== hold + 1 || !cl) begin errors++; $display("FAIL rand_timing[%0d]: got lat %0d dn %0d expected %0d %0d", i, lat, dc, exp_lat, hold + 1); end
            checks++; if (pc !== 0 || !bo || !do_) begin errors++; $display("FAIL rand_clean[%0d]: got proto %0d busy_ok %0d bus_ok %0d expected 0 1 1", i, pc, bo, do_); end
            if (wr && !oor) mm[a] = wd;
            if (!wr && (oor || mm.exists(a))) begin
                checks++;
                if (rd !== (oor ? 32'h0 : mm[a])) begin errors++; $display("FAIL rand_data[%0d] addr %h: got %h expected %h", i, a, rd, oor ? 32'h0 : mm[a]); end
            end
            checks++; if (b.addr_err !== model_err) begin errors++; $display("FAIL rand_addr_err[%0d]: got %b expected %b", i, b.addr_err, model_err); end
        end
    endtask

    task automatic test_reset_mid_write();
        int lat, dc, pc; logic [31:0] rd, old; bit bo, do_, cl;
        old = $urandom;
        xfer(1'b1, 32'd7, old, 0, -1, -5, lat, dc, rd, pc, bo, do_, cl);
        mm[32'd7] = old;
        b.addr = 32'd7; tb_oe = 1'b1; tb_data = ~old; b.write_q = 1'b1;
        @(negedge clk);
        checks++; if (b.bus_busy !== 1'b1) begin errors++; $display("FAIL mid_write_busy: got %b expected 1", b.bus_busy); end
        #2 rst = 1'b0;
        #1;
        model_err = 1'b0;
        checks++;
        if ({b.bus_busy, b.write_dn, b.read_dn, b.proto_err, b.addr_err} !== 5'b0) begin
            errors++; $display("FAIL async_reset_outputs: got %b expected 00000",
                {b.bus_busy, b.write_dn, b.read_dn, b.proto_err, b.addr_err});
        end
        b.write_q = 1'b0; tb_data = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        xfer(1'b0, 32'd7, 32'h0, 0, -1, -5, lat, dc, rd, pc, bo, do_, cl);
        checks++; if (rd !== old || lat !== RD_LAT || !cl) begin errors++; $display("FAIL reset_no_commit: got %h lat %0d expected %h %0d", rd, lat, old, RD_LAT); end
        checks++; if (b.addr_err !== model_err) begin errors++; $display("FAIL reset_addr_err: got %b expected %b", b.addr_err, model_err); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_held();
        test_early_drop();
        test_opposite();
        test_simultaneous();
        test_out_of_range();
        test_random();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side responder for the internal CPU bus. It serves the read_q/write_q requests issued by the CPU-side bus managers.
- Contains a word-addressed RAM, inserts a programmable number of wait states, and completes each transfer with a 4-phase read_dn/write_dn handshake.
- It drives the shared data bus only while a read response is being presented.
- It sits on the far end of addr/data/read_q/write_q, next to the dispatcher.

Parameters:
- ADDR_W, 32: width of addr (`ADDR_SIZE0+1).
- DATA_W, 32: width of data (`DATA_SIZE0+1).
- MEM_DEPTH, 256: number of words. Valid addresses are 0..MEM_DEPTH-1.
- RD_WAIT, 2: wait cycles between read acceptance and read_dn rising. Legal range 0..15.
- WR_WAIT, 1: wait cycles between write acceptance and write_dn rising. Legal range 0..15.

Ports:
- clk, input, 1: system clock. All state changes on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- addr, input, ADDR_W: word address. Held stable by the requester while its request is high.
- data, inout, DATA_W: shared data bus. Driven by this block only in RD_DONE, otherwise high-Z. Sampled as write data.
- read_q, input, 1: read request level.
- write_q, input, 1: write request level.
- read_dn, output, 1: read complete. Data is valid while this is high.
- write_dn, output, 1: write complete.
- bus_busy, output, 1: high from request acceptance until the handshake closes.
- addr_err, output, 1: sticky flag. Set by an out-of-range access.
- proto_err, output, 1: one-cycle pulse. Marks a protocol violation.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, wait counter=0.
  - read_dn=0, write_dn=0, bus_busy=0, addr_err=0, proto_err=0, data=Z.
  - RAM contents are not cleared.
  - Reset mid-transfer aborts it: no RAM write occurs unless the write was already committed.
- States: IDLE, RD_WAIT, RD_DONE, WR_WAIT, WR_DONE.
- IDLE:
  - read_q=1, write_q=0: latch addr, load counter=RD_WAIT, bus_busy=1, go to RD_WAIT.
  - write_q=1, read_q=0: latch addr and data, load counter=WR_WAIT, bus_busy=1, go to WR_WAIT.
  - Both high: no acceptance, proto_err pulses for one cycle, stay in IDLE. This repeats each cycle while both stay high.
- RD_WAIT:
  - Counter decrements each cycle.
  - When it reaches 0, register rd_data from RAM[latched addr], or 0 if the address is out of range (this also sets addr_err).
  - Go to RD_DONE.
  - With RD_WAIT=0, read_dn rises 2 cycles after the request edge is sampled. In general the latency is RD_WAIT+2 cycles.
- RD_DONE:
  - read_dn=1 and data=rd_data.
  - Both are held until read_q is sampled low.
  - In that cycle: read_dn=0, data=Z, bus_busy=0, go to IDLE.
- WR_WAIT:
  - Counter decrements.
  - At 0, commit the latched data to RAM[latched addr] if in range; if out of range, discard it and set addr_err.
  - Go to WR_DONE. Write latency is WR_WAIT+2 cycles to write_dn.
- WR_DONE:
  - write_dn=1 until write_q is sampled low.
  - Then write_dn=0, bus_busy=0, go to IDLE.
- Address and data are latched at acceptance. Changes on addr/data during the transfer are ignored.
- Request dropped early:
  - read_q falling in RD_WAIT, or write_q falling in WR_WAIT, does not abort the transfer.
  - The done flag rises for one cycle and is then cleared in the next cycle, because the request is already low.
  - proto_err pulses when the done flag rises.
- Opposite request during a transfer (e.g. write_q rising in RD_*): ignored and pulses proto_err. After returning to IDLE it is accepted normally.
- Back-to-back: the minimum gap is one IDLE cycle after done falls. A new request may already be high in that IDLE cycle.
- Address range check: addr >= MEM_DEPTH is out of range. All ADDR_W bits are compared; there is no wrap-around.
- addr_err clears only on reset.
- Only one transfer is outstanding at any time.

Test Plan:
- Write then read: write_q with addr=5, data=0xDEADBEEF -> write_dn rises 3 cycles after acceptance (WR_WAIT=1). Drop write_q, then read_q addr=5 -> read_dn rises after 4 cycles (RD_WAIT=2) with data=0xDEADBEEF. data is Z before read_dn and after read_q falls.
- Held handshake: keep read_q high 10 cycles past read_dn -> read_dn and data stay stable. bus_busy falls in the same cycle read_q is sampled low.
- Out of range: read addr=300 (MEM_DEPTH=256) -> data=0, read_dn completes, addr_err=1 and stays 1. A write to addr=256 leaves RAM[0] unchanged.
- Simultaneous requests: read_q=write_q=1 for 3 IDLE cycles -> 3 proto_err pulses, no dn, bus_busy=0. Then drop write_q -> the read proceeds.
- Reset mid-write: assert rst=0 in WR_WAIT for addr=7 -> outputs clear immediately (asynchronous) and RAM[7] keeps its old value. After release, a normal transfer completes.
- Early drop: write_q released one cycle after acceptance -> write still commits, write_dn is high for exactly 1 cycle, proto_err pulses once.
